ascon_round_seq: RTL
====================

# ascon_round_seq

Round sequencer sitting directly upstream of the one-bit permutation FSM. Accepts a permutation request for 1–12 rounds and issues one `start_permutation` pulse per round. Waits for the per-round completion pulse between rounds. Supplies the round constant bit-serially to the datapath during the add-constant phase, then signals permutation completion.

## Interface
Parameters:
- `WDT_LIMIT`, default 1023: watchdog cycle limit per round; used only with the watchdog compiled in.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: permutation request.
- `cmd_ready` out 1: sequencer idle; request accepted on `cmd_valid && cmd_ready`.
- `cmd_rounds` in 4: round count for the request. Values above 12 are clamped to 12.
- `start_permutation` out 1: one-cycle pulse that launches one round in the per-round FSM.
- `round_done` in 1: one-cycle pulse from the per-round FSM when its final phase completes.
- `const_shift` in 1: advance the constant shift register by one bit.
- `const_bit` out 1: current round-constant bit, LSB-first.
- `round_idx` out 4: absolute Ascon round index, 0..11.
- `busy` out 1: request in progress.
- `perm_done` out 1: one-cycle pulse after the last round completes.
- `wdt_err` out 1: sticky watchdog error; present only with `ASCON_SEQ_WDT_EN`.

## Operation
- Round constant for index i is `((15-i)<<4) | i`. Index 0 gives 0xF0, index 11 gives 0x4B.
- A request for a rounds starts at i = 12-a and runs through i = 11.
- State machine: `IDLE` → `LAUNCH` → `WAIT` → (`LAUNCH` | `DONE`) → `IDLE`.
- `IDLE`:
  - `cmd_ready=1`.
  - On accept with rounds ≥1: latch remaining = rounds, set `round_idx` = 12-rounds, load the constant register, then go to `LAUNCH`.
  - On accept with rounds = 0: go directly to `DONE`. No `start_permutation` is issued.
- `LAUNCH`: `start_permutation=1` for exactly one cycle, then go to `WAIT`.
- `WAIT`:
  - On `round_done` with remaining = 1: go to `DONE`.
  - On `round_done` with remaining > 1: decrement remaining, increment `round_idx`, reload the constant register with the new constant, go to `LAUNCH`.
- `DONE`: `perm_done=1` for one cycle, then go to `IDLE`.
- Constant register (8 bits):
  - Shifts right on `const_shift`, only in `WAIT`; zero is shifted in at the MSB.
  - `const_bit` is reg[0]. After 8 shifts `const_bit` = 0 until the next reload.
  - `const_shift` is ignored in `IDLE`, `LAUNCH` and `DONE`.
- `round_done` is ignored outside `WAIT`, including the same cycle as `start_permutation`.
- `cmd_valid` while busy: not accepted, no effect; `cmd_ready=0`.
- `busy` = 1 in `LAUNCH`, `WAIT` and `DONE`.

## Timing
- Reset values:
  - State `IDLE`, `cmd_ready=1`, `busy=0`.
  - `start_permutation=0`, `perm_done=0`, `const_bit=0`, `round_idx=0`.
  - Constant register 0, `wdt_err=0`.
- Accept at edge N:
  - `start_permutation` is high in cycle N+1.
  - `const_bit` is valid from N+1.
- `round_done` at edge M (non-final round): next `start_permutation` in cycle M+1, with the new constant valid at M+1.
- Final `round_done` at edge M: `perm_done` in cycle M+1, `cmd_ready` in cycle M+2.
- Back-to-back requests: the earliest next accept is cycle M+2.
- Rounds = 0: `perm_done` one cycle after accept.
- Reset mid-operation: immediate return to reset values. No `perm_done` is issued.

## Configuration
- `ASCON_SEQ_WDT_EN` defined:
  - A 10-bit counter clears on every `LAUNCH` and increments each `WAIT` cycle.
  - When it reaches `WDT_LIMIT` without `round_done`: `wdt_err` is set, the state goes to `IDLE`, and no `perm_done` is issued.
  - `wdt_err` clears on the next accepted request.
- Not defined: no counter, no `wdt_err` port, and `WAIT` holds indefinitely.

## Structure
- `ascon_seq_pkg`:
  - State enum.
  - `MAX_ROUNDS=12`.
  - Round-constant function of the index.
- Sub-module `ascon_rc_shifter`: holds the 8-bit constant register, with load (index) and shift controls; drives `const_bit`.

## Test plan
- 12-round request:
  - 12 `start_permutation` pulses and `round_idx` 0..11.
  - Constants serialised LSB-first, 0xF0 first and 0x4B last.
  - One `perm_done` after the 12th `round_done`.
- `cmd_rounds=6`:
  - First constant 0x96 (i=6), last 0x4B.
  - Exactly 6 launches.
- `cmd_rounds=0` → `perm_done` one cycle after accept, with zero launches. `cmd_rounds=15` → behaves as 12.
- `cmd_valid` held during a run, plus `round_done` injected during `LAUNCH`/`IDLE`:
  - No second accept.
  - Injected pulses are ignored; the round count is unchanged.
- Assert `rst` low in `WAIT` of round 3 → all outputs return to reset values immediately, with no `perm_done`. A new request afterwards restarts from the first round.
- `ASCON_SEQ_WDT_EN`, `WDT_LIMIT=20`, `round_done` withheld:
  - `wdt_err` goes to 1 after 20 `WAIT` cycles, `cmd_ready` returns, and no `perm_done` is issued.
  - `wdt_err` clears on the next request.

Source files
------------

// File: rtl/ascon_seq_pkg.sv
// ascon_seq_pkg: sequencer states, round limit and Ascon round-constant function
package ascon_seq_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  localparam int MAX_ROUNDS = 12;
  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'd15 - i, i};
  endfunction
endpackage

// File: rtl/ascon_rc_shifter.sv
// ascon_rc_shifter: 8-bit round-constant register, loaded by index and shifted out LSB-first
module ascon_rc_shifter
  import ascon_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] idx,
  input  logic       shift,
  output logic       const_bit
);
  logic [7:0] r;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r <= '0;
    else if (load) r <= rc(idx);
    else if (shift) r <= {1'b0, r[7:1]};
  assign const_bit = r[0];
endmodule

// File: rtl/ascon_round_seq.sv
// ascon_round_seq: issues one start pulse per Ascon round and serialises round constants
// Optional per-round watchdog with sticky wdt_err when ASCON_SEQ_WDT_EN is defined.
module ascon_round_seq
  import ascon_seq_pkg::*;
#(
  parameter int WDT_LIMIT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_rounds,
  output logic       start_permutation,
  input  logic       round_done,
  input  logic       const_shift,
  output logic       const_bit,
  output logic [3:0] round_idx,
  output logic       busy,
  output logic       perm_done
`ifdef ASCON_SEQ_WDT_EN
  ,
  output logic       wdt_err
`endif
);
  state_t state;
  logic [3:0] rem;
  logic [3:0] rounds;
  logic accept, step, last, load;
  logic [3:0] load_idx;
  assign rounds = cmd_rounds > 4'(MAX_ROUNDS) ? 4'(MAX_ROUNDS) : cmd_rounds;
  assign accept = cmd_valid && state == IDLE;
  assign step = state == WAIT && round_done;
  assign last = rem == 4'd1;
  assign load = (accept && rounds != 4'd0) || (step && !last);
  assign load_idx = accept ? 4'(MAX_ROUNDS) - rounds : round_idx + 4'd1;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign start_permutation = state == LAUNCH;
  assign perm_done = state == DONE;
`ifdef ASCON_SEQ_WDT_EN
  logic [9:0] wdt_cnt;
  logic wdt_hit;
  assign wdt_hit = state == WAIT && !round_done && wdt_cnt == 10'(WDT_LIMIT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wdt_cnt <= '0;
      wdt_err <= 1'b0;
    end else begin
      wdt_cnt <= state == LAUNCH ? 10'd0 : state == WAIT ? wdt_cnt + 10'd1 : wdt_cnt;
      wdt_err <= accept ? 1'b0 : wdt_hit ? 1'b1 : wdt_err;
    end
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      rem <= '0;
      round_idx <= '0;
    end else
      case (state)
        IDLE: if (cmd_valid) begin
          state <= rounds == 4'd0 ? DONE : LAUNCH;
          rem <= rounds;
          if (rounds != 4'd0) round_idx <= load_idx;
        end
        LAUNCH: state <= WAIT;
        WAIT: if (round_done) begin
          state <= last ? DONE : LAUNCH;
          if (!last) begin
            rem <= rem - 4'd1;
            round_idx <= load_idx;
          end
        end
`ifdef ASCON_SEQ_WDT_EN
        else if (wdt_hit) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
  ascon_rc_shifter u_rc (
    .clk(clk),
    .rst(rst),
    .load(load),
    .idx(load_idx),
    .shift(const_shift && state == WAIT),
    .const_bit(const_bit)
  );
endmodule
